// File: rtl/nios_system_nios2_group_21_oci_dct_packer_pkg.sv
// Shared widths and FSM encoding for the OCI trace code packer.
package nios_system_nios2_group_21_oci_dct_packer_pkg;

  localparam int unsigned SLOT_W = 3;
  localparam int unsigned SLOTS  = 10;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BUF_W  = SLOT_W * SLOTS;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDrain = 2'd1,
    StEnded = 2'd2
  } state_e;

endpackage

// File: rtl/nios_system_nios2_group_21_oci_dct_slot_insert.sv
// Combinational insert of one trace code into slot idx of the accumulator.
module nios_system_nios2_group_21_oci_dct_slot_insert
  import nios_system_nios2_group_21_oci_dct_packer_pkg::*;
(
  input  logic [BUF_W-1:0]  acc,
  input  logic [CNT_W-1:0]  idx,
  input  logic [SLOT_W-1:0] code,
  input  logic              en,
  output logic [BUF_W-1:0]  acc_nx
);

  always_comb begin
    acc_nx = acc;
    if (en) begin
      for (int i = 0; i < int'(SLOTS); i++) begin
        if (idx == CNT_W'(i)) acc_nx[i*SLOT_W +: SLOT_W] = code;
      end
    end
  end

endmodule

// File: rtl/nios_system_nios2_group_21_oci_dct_packer.sv
// Packs 3-bit trace codes into 30-bit packets; drains and reports end of test after a stop.
module nios_system_nios2_group_21_oci_dct_packer
  import nios_system_nios2_group_21_oci_dct_packer_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tr_valid,
  input  logic [SLOT_W-1:0] tr_code,
  output logic              tr_ready,
  input  logic              flush,
  input  logic              stop,
  output logic              pkt_valid,
  input  logic              pkt_ready,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              test_ending,
  output logic              test_has_ended
);

  state_e             state_q;
  logic [BUF_W-1:0]   acc_q;
  logic [BUF_W-1:0]   acc_nx;
  logic [CNT_W-1:0]   acc_cnt_q;
  logic [CNT_W-1:0]   acc_cnt_nx;
  logic               flush_pend_q;
  logic               flush_pend_d;
  logic               ready_en_q;
  logic               accept;
  logic               out_free;
  logic               flush_eff;
  logic               load;

  // ready_en_q keeps tr_ready low while reset is held.
  assign tr_ready   = ready_en_q && (state_q == StRun) && (acc_cnt_q != CNT_W'(SLOTS));
  assign accept     = tr_valid && tr_ready;
  assign acc_cnt_nx = acc_cnt_q + CNT_W'(accept);
  assign out_free   = !pkt_valid || pkt_ready;
  assign flush_eff  = (flush && (state_q != StEnded)) || flush_pend_q || (state_q == StDrain);
  assign load       = out_free &&
                      ((acc_cnt_nx == CNT_W'(SLOTS)) || (flush_eff && (acc_cnt_nx != '0)));

  // A flush that cannot load yet is remembered; an empty flush leaves nothing pending.
  assign flush_pend_d = !load &&
                        (flush_pend_q || (flush && (state_q != StEnded) && (acc_cnt_nx != '0)));

  nios_system_nios2_group_21_oci_dct_slot_insert u_slot_insert (
    .acc    (acc_q),
    .idx    (acc_cnt_q),
    .code   (tr_code),
    .en     (accept),
    .acc_nx (acc_nx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StRun;
      acc_q          <= '0;
      acc_cnt_q      <= '0;
      flush_pend_q   <= 1'b0;
      ready_en_q     <= 1'b0;
      pkt_valid      <= 1'b0;
      dct_buffer     <= '0;
      dct_count      <= '0;
      test_ending    <= 1'b0;
      test_has_ended <= 1'b0;
    end else begin
      ready_en_q   <= 1'b1;
      flush_pend_q <= flush_pend_d;
      if (load) begin
        dct_buffer <= acc_nx;
        dct_count  <= acc_cnt_nx;
        pkt_valid  <= 1'b1;
        acc_q      <= '0;
        acc_cnt_q  <= '0;
      end else begin
        if (pkt_valid && pkt_ready) pkt_valid <= 1'b0;
        acc_q     <= acc_nx;
        acc_cnt_q <= acc_cnt_nx;
      end
      case (state_q)
        StRun: begin
          if (stop) begin
            state_q     <= StDrain;
            test_ending <= 1'b1;
          end
        end
        StDrain: begin
          if ((acc_cnt_q == '0) && !pkt_valid) begin
            state_q        <= StEnded;
            test_has_ended <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nios_system_nios2_group_21_oci_dct_packer.sv
// Directed self-checking bench for the OCI trace code packer.
module tb_nios_system_nios2_group_21_oci_dct_packer;

  logic        clk;
  logic        reset_n;
  logic        tr_valid;
  logic [2:0]  tr_code;
  logic        tr_ready;
  logic        flush;
  logic        stop;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_ending;
  logic        test_has_ended;

  int checks;
  int failures;

  nios_system_nios2_group_21_oci_dct_packer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .tr_valid       (tr_valid),
    .tr_code        (tr_code),
    .tr_ready       (tr_ready),
    .flush          (flush),
    .stop           (stop),
    .pkt_valid      (pkt_valid),
    .pkt_ready      (pkt_ready),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    tr_valid  = 1'b0;
    tr_code   = 3'd0;
    flush     = 1'b0;
    stop      = 1'b0;
    pkt_ready = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic send(input logic [2:0] code);
    tr_valid = 1'b1;
    tr_code  = code;
    checks++;
    if (tr_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready: tr_ready=%b want 1 (code %0d)", tr_ready, code);
    end
    step();
    tr_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    tr_valid  = 1'b0;
    tr_code   = 3'd0;
    flush     = 1'b0;
    stop      = 1'b0;
    pkt_ready = 1'b0;
    #3;
    checks++;
    if ({tr_ready, pkt_valid, dct_buffer, dct_count, test_ending, test_has_ended} !== '0) begin
      failures++;
      $display("FAIL reset_held: rdy=%b v=%b buf=%o cnt=%0d end=%b ended=%b want all 0",
               tr_ready, pkt_valid, dct_buffer, dct_count, test_ending, test_has_ended);
    end
    step();
    reset_n = 1'b1;
    step();
    checks++;
    if (tr_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: tr_ready=%b want 1", tr_ready);
    end
    checks++;
    if ({pkt_valid, dct_buffer, dct_count, test_ending, test_has_ended} !== '0) begin
      failures++;
      $display("FAIL reset_idle: v=%b buf=%o cnt=%0d end=%b ended=%b want all 0",
               pkt_valid, dct_buffer, dct_count, test_ending, test_has_ended);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    checks++;
    if (pkt_valid !== 1'b0) begin
      failures++;
      $display("FAIL empty_flush: pkt_valid=%b want 0", pkt_valid);
    end
  endtask

  task automatic test_full_packet();
    logic [2:0] codes [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
    pkt_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(codes[i]);
    checks++;
    if (pkt_valid !== 1'b1 || dct_count !== 4'd10 || dct_buffer !== 30'o2107654321) begin
      failures++;
      $display("FAIL full_packet: v=%b cnt=%0d buf=%o want v=1 cnt=10 buf=2107654321",
               pkt_valid, dct_count, dct_buffer);
    end
    step();
    checks++;
    if (pkt_valid !== 1'b0) begin
      failures++;
      $display("FAIL full_taken: pkt_valid=%b want 0", pkt_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [29:0] exp1;
    logic [29:0] exp2;
    logic [2:0]  c;
    exp1 = '0;
    exp2 = '0;
    pkt_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      c = 3'((i * 5 + 3) % 8);
      if (i < 10) exp1[i*3 +: 3] = c;
      else        exp2[(i-10)*3 +: 3] = c;
      send(c);
    end
    checks++;
    if (tr_ready !== 1'b0) begin
      failures++;
      $display("FAIL stall_ready: tr_ready=%b want 0", tr_ready);
    end
    checks++;
    if (pkt_valid !== 1'b1 || dct_count !== 4'd10 || dct_buffer !== exp1) begin
      failures++;
      $display("FAIL stall_pkt1: v=%b cnt=%0d buf=%o want v=1 cnt=10 buf=%o",
               pkt_valid, dct_count, dct_buffer, exp1);
    end
    pkt_ready = 1'b1;
    step();
    checks++;
    if (pkt_valid !== 1'b1 || dct_count !== 4'd10 || dct_buffer !== exp2) begin
      failures++;
      $display("FAIL stall_pkt2: v=%b cnt=%0d buf=%o want v=1 cnt=10 buf=%o",
               pkt_valid, dct_count, dct_buffer, exp2);
    end
    checks++;
    if (tr_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_resume: tr_ready=%b want 1", tr_ready);
    end
    step();
    checks++;
    if (pkt_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_drained: pkt_valid=%b want 0", pkt_valid);
    end
  endtask

  task automatic test_flush();
    pkt_ready = 1'b1;
    send(3'd5);
    send(3'd5);
    send(3'd5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (pkt_valid !== 1'b1 || dct_count !== 4'd3 || dct_buffer !== 30'o555) begin
      failures++;
      $display("FAIL flush_partial: v=%b cnt=%0d buf=%o want v=1 cnt=3 buf=555",
               pkt_valid, dct_count, dct_buffer);
    end
    step();
    send(3'd1);
    send(3'd2);
    flush = 1'b1;
    send(3'd3);
    flush = 1'b0;
    checks++;
    if (pkt_valid !== 1'b1 || dct_count !== 4'd3 || dct_buffer !== 30'o321) begin
      failures++;
      $display("FAIL flush_with_accept: v=%b cnt=%0d buf=%o want v=1 cnt=3 buf=321",
               pkt_valid, dct_count, dct_buffer);
    end
    step();
  endtask

  task automatic test_flush_held();
    pkt_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(3'd7);
    send(3'd3);
    send(3'd4);
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    step();
    checks++;
    if (pkt_valid !== 1'b1 || dct_count !== 4'd10 || dct_buffer !== 30'o7777777777) begin
      failures++;
      $display("FAIL held_stable: v=%b cnt=%0d buf=%o want v=1 cnt=10 buf=7777777777",
               pkt_valid, dct_count, dct_buffer);
    end
    pkt_ready = 1'b1;
    step();
    checks++;
    if (pkt_valid !== 1'b1 || dct_count !== 4'd2 || dct_buffer !== 30'o43) begin
      failures++;
      $display("FAIL held_pending: v=%b cnt=%0d buf=%o want v=1 cnt=2 buf=43",
               pkt_valid, dct_count, dct_buffer);
    end
    step();
    checks++;
    if (pkt_valid !== 1'b0) begin
      failures++;
      $display("FAIL held_drained: pkt_valid=%b want 0", pkt_valid);
    end
  endtask

  task automatic test_stop();
    pkt_ready = 1'b1;
    send(3'd1);
    send(3'd2);
    send(3'd3);
    send(3'd4);
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if (test_ending !== 1'b1 || tr_ready !== 1'b0 || test_has_ended !== 1'b0) begin
      failures++;
      $display("FAIL stop_ending: end=%b rdy=%b ended=%b want 1 0 0",
               test_ending, tr_ready, test_has_ended);
    end
    step();
    checks++;
    if (pkt_valid !== 1'b1 || dct_count !== 4'd4 || dct_buffer !== 30'o4321) begin
      failures++;
      $display("FAIL stop_packet: v=%b cnt=%0d buf=%o want v=1 cnt=4 buf=4321",
               pkt_valid, dct_count, dct_buffer);
    end
    step();
    checks++;
    if (pkt_valid !== 1'b0 || test_has_ended !== 1'b0) begin
      failures++;
      $display("FAIL stop_handoff: v=%b ended=%b want 0 0", pkt_valid, test_has_ended);
    end
    step();
    checks++;
    if (test_has_ended !== 1'b1) begin
      failures++;
      $display("FAIL stop_ended: test_has_ended=%b want 1", test_has_ended);
    end
    stop = 1'b1;
    flush = 1'b1;
    step();
    stop = 1'b0;
    flush = 1'b0;
    step();
    checks++;
    if (test_has_ended !== 1'b1 || test_ending !== 1'b1 || tr_ready !== 1'b0 ||
        pkt_valid !== 1'b0) begin
      failures++;
      $display("FAIL stop_ignored: ended=%b end=%b rdy=%b v=%b want 1 1 0 0",
               test_has_ended, test_ending, tr_ready, pkt_valid);
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    pkt_ready = 1'b0;
    send(3'd6);
    send(3'd6);
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
    checks++;
    if (pkt_valid !== 1'b1 || test_ending !== 1'b1 || dct_count !== 4'd2) begin
      failures++;
      $display("FAIL drain_held: v=%b end=%b cnt=%0d want 1 1 2", pkt_valid, test_ending,
               dct_count);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({tr_ready, pkt_valid, dct_buffer, dct_count, test_ending, test_has_ended} !== '0) begin
      failures++;
      $display("FAIL drain_reset: rdy=%b v=%b buf=%o cnt=%0d end=%b ended=%b want all 0",
               tr_ready, pkt_valid, dct_buffer, dct_count, test_ending, test_has_ended);
    end
    step();
    reset_n = 1'b1;
    step();
    checks++;
    if (tr_ready !== 1'b1 || test_ending !== 1'b0 || pkt_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain_recover: rdy=%b end=%b v=%b want 1 0 0", tr_ready, test_ending,
               pkt_valid);
    end
  endtask

  task automatic test_stop_empty();
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if (test_ending !== 1'b1 || test_has_ended !== 1'b0) begin
      failures++;
      $display("FAIL empty_stop_n1: end=%b ended=%b want 1 0", test_ending, test_has_ended);
    end
    step();
    checks++;
    if (test_has_ended !== 1'b1 || pkt_valid !== 1'b0) begin
      failures++;
      $display("FAIL empty_stop_n2: ended=%b v=%b want 1 0", test_has_ended, pkt_valid);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_full_packet();
    test_back_to_back();
    test_flush();
    test_flush_held();
    test_stop();
    test_reset_mid_drain();
    test_stop_empty();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
